// File: rtl/aud_pkg.sv
// Shared audio-path definitions: sample/address widths and the recorder
// state encoding (the codes also drive the seven-segment display).
package aud_pkg;

  localparam int SAMPLE_W = 16;
  localparam int ADDR_W   = 20;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_LR = 3'd1,
    SKIP    = 3'd2,
    SHIFT   = 3'd3,
    WRITE   = 3'd4,
    PAUSED  = 3'd5
  } rec_state_t;

endpackage

// File: rtl/aud_edge_sync.sv
// Two-flop synchroniser for a codec-domain signal plus single-cycle
// rise/fall pulses taken from the synchronised copy.
module aud_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  // [0],[1] are the synchroniser flops, [2] holds the previous synced level
  logic [2:0] sync_q;

  // Shift the asynchronous input through the synchroniser and history flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], din};
    end
  end

  assign rise = sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/aud_recorder.sv
// WM8731 ADC capture (I2S, codec master) producing one-cycle SRAM write
// strobes. Build option: define AUD_REC_STEREO_EN to capture both channels
// (left at even, right at odd addresses); the default build is left-only.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | not recording; i_start clears address, length and full flag
// WAIT_LR | waiting for the lrck edge that opens the wanted half-frame
// SKIP    | swallowing the first bclk rise (I2S one-bit delay)
// SHIFT   | shifting SAMPLE_W bits in, MSB first
// WRITE   | o_valid high for this single cycle
// PAUSED  | no capture; i_start resumes at the current address
module aud_recorder #(
  parameter int                SAMPLE_W  = aud_pkg::SAMPLE_W,
  parameter int                ADDR_W    = aud_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}}
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_pause,
  input  logic                i_stop,
  input  logic                i_aud_bclk,
  input  logic                i_aud_lrck,
  input  logic                i_aud_adcdat,
  output logic [ADDR_W-1:0]   o_address,
  output logic [SAMPLE_W-1:0] o_data,
  output logic                o_valid,
  output logic [ADDR_W-1:0]   o_len,
  output logic                o_full,
  output logic [2:0]          o_state
);

  import aud_pkg::*;

`ifdef AUD_REC_STEREO_EN
  localparam bit STEREO = 1'b1;
`else
  localparam bit STEREO = 1'b0;
`endif

  localparam int                CNT_W    = $clog2(SAMPLE_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SAMPLE_W - 1);

  rec_state_t          state;
  logic                chan;        // 0 = left half-frame expected, 1 = right
  logic [CNT_W-1:0]    bit_cnt;     // bits still to shift, minus one
  logic [SAMPLE_W-1:0] shreg;
  logic [ADDR_W-1:0]   wr_ptr;      // next address to write
  logic [1:0]          dat_sync;
  logic                bclk_rise;
  logic                bclk_fall_unused;
  logic                lrck_rise;
  logic                lrck_fall;
  logic                frame_edge;
  logic                frame_abort;
  logic                dat;
  logic [SAMPLE_W-1:0] sample_next;
  logic [ADDR_W-1:0]   len_next;

  aud_edge_sync u_bclk_sync (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .din   (i_aud_bclk),
    .rise  (bclk_rise),
    .fall  (bclk_fall_unused)
  );

  aud_edge_sync u_lrck_sync (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .din   (i_aud_lrck),
    .rise  (lrck_rise),
    .fall  (lrck_fall)
  );

  // Data only needs the synchroniser; its latency matches the bclk edge path
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dat_sync <= '0;
    end else begin
      dat_sync <= {dat_sync[0], i_aud_adcdat};
    end
  end

  assign dat         = dat_sync[1];
  assign sample_next = {shreg[SAMPLE_W-2:0], dat};
  // lrck low = left: a fall opens the left half, a rise opens the right one
  assign frame_edge  = chan ? lrck_rise : lrck_fall;
  assign frame_abort = chan ? lrck_fall : lrck_rise;
  // Length saturates rather than wrapping when the whole memory is filled
  assign len_next    = (o_len == {ADDR_W{1'b1}}) ? o_len : o_len + 1'b1;
  assign o_state     = state;

  // Capture FSM: frame alignment, shifting, write strobe and take bookkeeping
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      chan      <= 1'b0;
      bit_cnt   <= '0;
      shreg     <= '0;
      wr_ptr    <= '0;
      o_address <= '0;
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_len     <= '0;
      o_full    <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            state     <= WAIT_LR;
            chan      <= 1'b0;
            wr_ptr    <= '0;
            o_address <= '0;
            o_len     <= '0;
            o_full    <= 1'b0;
          end
        end
        WAIT_LR: begin
          if (i_stop) begin
            state <= IDLE;
          end else if (i_pause) begin
            state <= PAUSED;
          end else if (frame_edge) begin
            state <= SKIP;
          end
        end
        SKIP: begin
          if (i_stop) begin
            state <= IDLE;
          end else if (i_pause) begin
            state <= PAUSED;
          end else if (bclk_rise) begin
            state   <= SHIFT;
            bit_cnt <= CNT_LAST;
          end
        end
        SHIFT: begin
          if (i_stop) begin
            state <= IDLE;
          end else if (i_pause) begin
            state <= PAUSED;
          end else if (frame_abort) begin
            // Short half-frame: drop it and realign on the next left frame
            state <= WAIT_LR;
            chan  <= 1'b0;
          end else if (bclk_rise) begin
            shreg <= sample_next;
            if (bit_cnt == '0) begin
              state     <= WRITE;
              o_valid   <= 1'b1;
              o_data    <= sample_next;
              o_address <= wr_ptr;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
        end
        WRITE: begin
          // The strobe is already on the pins this cycle, so it always counts
          o_len <= len_next;
          if (i_stop) begin
            state <= IDLE;
          end else if (wr_ptr == ADDR_LAST) begin
            o_full <= 1'b1;
            state  <= IDLE;
          end else begin
            wr_ptr <= wr_ptr + 1'b1;
            chan   <= STEREO ? ~chan : 1'b0;
            state  <= i_pause ? PAUSED : WAIT_LR;
          end
        end
        PAUSED: begin
          if (i_stop) begin
            state <= IDLE;
          end else if (i_start) begin
            state <= WAIT_LR;
            chan  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aud_recorder.sv
// Directed bench for aud_recorder driving an I2S codec model. The DUT is
// built with a four-word memory so the full-memory path is reachable.
module tb_aud_recorder;

  localparam logic [19:0] LAST = 20'h00003;
`ifdef AUD_REC_STEREO_EN
  localparam bit ST = 1'b1;
`else
  localparam bit ST = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        i_start = 1'b0;
  logic        i_pause = 1'b0;
  logic        i_stop = 1'b0;
  logic        i_aud_bclk = 1'b0;
  logic        i_aud_lrck = 1'b1;
  logic        i_aud_adcdat = 1'b0;
  logic [19:0] o_address;
  logic [15:0] o_data;
  logic        o_valid;
  logic [19:0] o_len;
  logic        o_full;
  logic [2:0]  o_state;

  int checks = 0;
  int failures = 0;
  int dbl = 0;
  logic prev_v = 1'b0;

  logic [19:0] cap_a[$];
  logic [15:0] cap_d[$];
  logic [19:0] exp_a[$];
  logic [15:0] exp_d[$];
  logic [19:0] m_ptr;
  logic [19:0] m_len;
  logic        m_full;

  aud_recorder #(.ADDR_LAST(LAST)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_pause      (i_pause),
    .i_stop       (i_stop),
    .i_aud_bclk   (i_aud_bclk),
    .i_aud_lrck   (i_aud_lrck),
    .i_aud_adcdat (i_aud_adcdat),
    .o_address    (o_address),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_len        (o_len),
    .o_full       (o_full),
    .o_state      (o_state)
  );

  always #5 i_clk = ~i_clk;

  // Write monitor, sampled mid-cycle
  always @(negedge i_clk) begin
    if (o_valid === 1'b1) begin
      cap_a.push_back(o_address);
      cap_d.push_back(o_data);
      if (prev_v) dbl <= dbl + 1;
    end
    prev_v <= (o_valid === 1'b1);
  end

  task automatic nclk(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  // kind: 1 start, 2 pause, 3 stop, 4 stop+pause
  task automatic pulse(input int kind);
    @(negedge i_clk);
    i_start = (kind == 1);
    i_pause = (kind == 2) || (kind == 4);
    i_stop  = (kind == 3) || (kind == 4);
    @(negedge i_clk);
    i_start = 1'b0;
    i_pause = 1'b0;
    i_stop  = 1'b0;
  endtask

  // One bclk period (8 clocks). A pulse injected here is seen by the DUT on
  // the same cycle it detects this bclk rise.
  task automatic bit_cycle(input logic d, input int inj);
    i_aud_bclk   = 1'b0;
    i_aud_adcdat = d;
    nclk(4);
    i_aud_bclk = 1'b1;
    if (inj == 0) begin
      nclk(4);
    end else begin
      nclk(2);
      i_pause = (inj == 2) || (inj == 4);
      i_stop  = (inj == 4);
      nclk(1);
      i_pause = 1'b0;
      i_stop  = 1'b0;
      nclk(1);
    end
  endtask

  task automatic send_half(input logic lr, input logic [15:0] val, input int nbits,
                           input int pad, input int inj_bit, input int inj);
    i_aud_lrck = lr;
    bit_cycle(1'b1, 0);
    for (int i = 0; i < nbits; i++) bit_cycle(val[15-i], (i == inj_bit) ? inj : 0);
    for (int i = 0; i < pad; i++) bit_cycle(1'b1, 0);
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_half(1'b0, l, 16, 3, -1, 0);
    send_half(1'b1, r, 16, 3, -1, 0);
  endtask

  task automatic m_start();
    m_ptr = '0;
    m_len = '0;
    m_full = 1'b0;
    exp_a.delete();
    exp_d.delete();
    cap_a.delete();
    cap_d.delete();
  endtask

  task automatic m_write(input logic [15:0] d);
    if (!m_full) begin
      exp_a.push_back(m_ptr);
      exp_d.push_back(d);
      m_len = m_len + 1;
      if (m_ptr == LAST) m_full = 1'b1;
      else m_ptr = m_ptr + 1;
    end
  endtask

  task automatic m_frame(input logic [15:0] l, input logic [15:0] r);
    m_write(l);
    if (ST) m_write(r);
  endtask

  task automatic test_reset();
    #2 i_rst_n = 1'b0;
    #6;
    checks += 6;
    if (o_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", o_valid); end
    if (o_address !== '0) begin failures++; $display("FAIL rst_addr got=%h exp=0", o_address); end
    if (o_data !== '0) begin failures++; $display("FAIL rst_data got=%h exp=0", o_data); end
    if (o_len !== '0) begin failures++; $display("FAIL rst_len got=%h exp=0", o_len); end
    if (o_full !== 1'b0) begin failures++; $display("FAIL rst_full got=%b exp=0", o_full); end
    if (o_state !== 3'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", o_state); end
    nclk(2);
    i_rst_n = 1'b1;
    nclk(2);
  endtask

  task automatic test_single();
    m_start();
    pulse(1);
    checks++;
    if (o_state !== 3'd1) begin failures++; $display("FAIL single_start_state got=%0d exp=1", o_state); end
    send_frame(16'hA5C3, 16'h5A5A);
    m_frame(16'hA5C3, 16'h5A5A);
    checks++;
    if (cap_a.size() != exp_a.size()) begin failures++; $display("FAIL single_count got=%0d exp=%0d", cap_a.size(), exp_a.size()); end
    foreach (exp_a[i]) if (i < cap_a.size()) begin
      checks++;
      if (cap_a[i] !== exp_a[i] || cap_d[i] !== exp_d[i]) begin
        failures++; $display("FAIL single_wr%0d got=%h:%h exp=%h:%h", i, cap_a[i], cap_d[i], exp_a[i], exp_d[i]);
      end
    end
    checks += 2;
    if (o_len !== m_len) begin failures++; $display("FAIL single_len got=%0d exp=%0d", o_len, m_len); end
    if (o_state !== 3'd1) begin failures++; $display("FAIL single_state got=%0d exp=1", o_state); end
  endtask

  task automatic test_back_to_back();
    pulse(3);
    checks += 2;
    if (o_state !== 3'd0) begin failures++; $display("FAIL b2b_stop_state got=%0d exp=0", o_state); end
    if (o_len !== m_len) begin failures++; $display("FAIL b2b_len_hold got=%0d exp=%0d", o_len, m_len); end
    m_start();
    pulse(1);
    send_frame(16'h0001, 16'h0F0F); m_frame(16'h0001, 16'h0F0F);
    send_frame(16'h8000, 16'hF0F0); m_frame(16'h8000, 16'hF0F0);
    send_frame(16'hFFFF, 16'h00FF); m_frame(16'hFFFF, 16'h00FF);
    checks++;
    if (cap_a.size() != exp_a.size()) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", cap_a.size(), exp_a.size()); end
    foreach (exp_a[i]) if (i < cap_a.size()) begin
      checks++;
      if (cap_a[i] !== exp_a[i] || cap_d[i] !== exp_d[i]) begin
        failures++; $display("FAIL b2b_wr%0d got=%h:%h exp=%h:%h", i, cap_a[i], cap_d[i], exp_a[i], exp_d[i]);
      end
    end
    checks += 4;
    if (o_len !== m_len) begin failures++; $display("FAIL b2b_len got=%0d exp=%0d", o_len, m_len); end
    if (o_full !== m_full) begin failures++; $display("FAIL b2b_full got=%b exp=%b", o_full, m_full); end
    if (o_address !== exp_a[$]) begin failures++; $display("FAIL b2b_addr_hold got=%h exp=%h", o_address, exp_a[$]); end
    if (o_data !== exp_d[$]) begin failures++; $display("FAIL b2b_data_hold got=%h exp=%h", o_data, exp_d[$]); end
  endtask

  task automatic test_pause();
    pulse(3);
    m_start();
    pulse(1);
    send_frame(16'h1111, 16'h2222); m_frame(16'h1111, 16'h2222);
    send_half(1'b0, 16'h3333, 16, 3, 6, 2);
    checks++;
    if (o_state !== 3'd5) begin failures++; $display("FAIL pause_state got=%0d exp=5", o_state); end
    send_half(1'b1, 16'h4444, 16, 3, -1, 0);
    checks += 2;
    if (o_state !== 3'd5) begin failures++; $display("FAIL pause_hold got=%0d exp=5", o_state); end
    if (cap_a.size() != exp_a.size()) begin failures++; $display("FAIL pause_nowrite got=%0d exp=%0d", cap_a.size(), exp_a.size()); end
    pulse(1);
    checks++;
    if (o_state !== 3'd1) begin failures++; $display("FAIL pause_resume got=%0d exp=1", o_state); end
    send_frame(16'h5555, 16'h6666); m_frame(16'h5555, 16'h6666);
    checks++;
    if (cap_a.size() != exp_a.size()) begin failures++; $display("FAIL pause_count got=%0d exp=%0d", cap_a.size(), exp_a.size()); end
    foreach (exp_a[i]) if (i < cap_a.size()) begin
      checks++;
      if (cap_a[i] !== exp_a[i] || cap_d[i] !== exp_d[i]) begin
        failures++; $display("FAIL pause_wr%0d got=%h:%h exp=%h:%h", i, cap_a[i], cap_d[i], exp_a[i], exp_d[i]);
      end
    end
    checks++;
    if (o_len !== m_len) begin failures++; $display("FAIL pause_len got=%0d exp=%0d", o_len, m_len); end
  endtask

  task automatic test_framing();
    pulse(3);
    m_start();
    pulse(1);
    send_half(1'b0, 16'h7E7E, 10, 0, -1, 0);
    send_half(1'b1, 16'h1357, 16, 3, -1, 0);
    checks += 2;
    if (o_state !== 3'd1) begin failures++; $display("FAIL frame_state got=%0d exp=1", o_state); end
    if (cap_a.size() != 0) begin failures++; $display("FAIL frame_discard got=%0d exp=0", cap_a.size()); end
    send_frame(16'hC3A5, 16'h2468); m_frame(16'hC3A5, 16'h2468);
    checks++;
    if (cap_a.size() != exp_a.size()) begin failures++; $display("FAIL frame_count got=%0d exp=%0d", cap_a.size(), exp_a.size()); end
    foreach (exp_a[i]) if (i < cap_a.size()) begin
      checks++;
      if (cap_a[i] !== exp_a[i] || cap_d[i] !== exp_d[i]) begin
        failures++; $display("FAIL frame_wr%0d got=%h:%h exp=%h:%h", i, cap_a[i], cap_d[i], exp_a[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_full();
    logic [15:0] v;
    pulse(3);
    m_start();
    pulse(1);
    for (int f = 0; f < 5; f++) begin
      v = 16'h1000 * 16'(f + 1);
      send_frame(v, v | 16'h0001);
      m_frame(v, v | 16'h0001);
    end
    checks++;
    if (cap_a.size() != exp_a.size()) begin failures++; $display("FAIL full_count got=%0d exp=%0d", cap_a.size(), exp_a.size()); end
    foreach (exp_a[i]) if (i < cap_a.size()) begin
      checks++;
      if (cap_a[i] !== exp_a[i] || cap_d[i] !== exp_d[i]) begin
        failures++; $display("FAIL full_wr%0d got=%h:%h exp=%h:%h", i, cap_a[i], cap_d[i], exp_a[i], exp_d[i]);
      end
    end
    checks += 4;
    if (o_full !== 1'b1) begin failures++; $display("FAIL full_flag got=%b exp=1", o_full); end
    if (o_state !== 3'd0) begin failures++; $display("FAIL full_state got=%0d exp=0", o_state); end
    if (o_len !== 20'd4) begin failures++; $display("FAIL full_len got=%0d exp=4", o_len); end
    if (o_address !== LAST) begin failures++; $display("FAIL full_addr got=%h exp=%h", o_address, LAST); end
    pulse(1);
    checks += 3;
    if (o_full !== 1'b0) begin failures++; $display("FAIL full_clear got=%b exp=0", o_full); end
    if (o_len !== '0) begin failures++; $display("FAIL full_len_clear got=%0d exp=0", o_len); end
    if (o_state !== 3'd1) begin failures++; $display("FAIL full_restart got=%0d exp=1", o_state); end
  endtask

  task automatic test_stop_priority();
    pulse(3);
    m_start();
    pulse(1);
    send_frame(16'h7777, 16'h8888); m_frame(16'h7777, 16'h8888);
    send_half(1'b0, 16'h9999, 16, 3, 15, 4);
    checks++;
    if (o_state !== 3'd0) begin failures++; $display("FAIL stop_state got=%0d exp=0", o_state); end
    send_half(1'b1, 16'hAAAA, 16, 3, -1, 0);
    checks++;
    if (cap_a.size() != exp_a.size()) begin failures++; $display("FAIL stop_count got=%0d exp=%0d", cap_a.size(), exp_a.size()); end
    foreach (exp_a[i]) if (i < cap_a.size()) begin
      checks++;
      if (cap_a[i] !== exp_a[i] || cap_d[i] !== exp_d[i]) begin
        failures++; $display("FAIL stop_wr%0d got=%h:%h exp=%h:%h", i, cap_a[i], cap_d[i], exp_a[i], exp_d[i]);
      end
    end
    checks += 2;
    if (o_len !== m_len) begin failures++; $display("FAIL stop_len got=%0d exp=%0d", o_len, m_len); end
    if (o_data !== exp_d[$]) begin failures++; $display("FAIL stop_data got=%h exp=%h", o_data, exp_d[$]); end
  endtask

  task automatic test_async_reset();
    m_start();
    pulse(1);
    send_frame(16'hC001, 16'hC002); m_frame(16'hC001, 16'hC002);
    send_half(1'b0, 16'hBEEF, 8, 0, -1, 0);
    checks += 2;
    if (o_state !== 3'd3) begin failures++; $display("FAIL arst_pre_state got=%0d exp=3", o_state); end
    if (o_len !== m_len) begin failures++; $display("FAIL arst_pre_len got=%0d exp=%0d", o_len, m_len); end
    #1 i_rst_n = 1'b0;
    #1;
    checks += 6;
    if (o_valid !== 1'b0) begin failures++; $display("FAIL arst_valid got=%b exp=0", o_valid); end
    if (o_address !== '0) begin failures++; $display("FAIL arst_addr got=%h exp=0", o_address); end
    if (o_data !== '0) begin failures++; $display("FAIL arst_data got=%h exp=0", o_data); end
    if (o_len !== '0) begin failures++; $display("FAIL arst_len got=%0d exp=0", o_len); end
    if (o_full !== 1'b0) begin failures++; $display("FAIL arst_full got=%b exp=0", o_full); end
    if (o_state !== 3'd0) begin failures++; $display("FAIL arst_state got=%0d exp=0", o_state); end
    i_aud_bclk = 1'b0;
    nclk(2);
    i_rst_n = 1'b1;
    nclk(2);
    checks += 2;
    if (o_state !== 3'd0) begin failures++; $display("FAIL arst_after got=%0d exp=0", o_state); end
    if (dbl != 0) begin failures++; $display("FAIL valid_width got=%0d long strobes exp=0", dbl); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_pause();
    test_framing();
    test_full();
    test_stop_priority();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
